// File: rtl/spatial_sequencer.sv
// Sweeps one registered multi-channel sample through the spatial accumulator, one channel per cycle.
// Optional `SPATIAL_SEQ_STALL_EN adds Stall_SI to freeze the sweep; CHANNEL_WIDTH macro sets feature width.
`ifndef CHANNEL_WIDTH
`define CHANNEL_WIDTH 2
`endif

module spatial_sequencer #(
  parameter int MOD0_CH = 32,
  parameter int MOD1_CH = 77,
  parameter int MOD2_CH = 108,
  localparam int NUM_CH = MOD0_CH + MOD1_CH + MOD2_CH,
  localparam int IDX_W  = $clog2(NUM_CH),
  localparam int CW     = `CHANNEL_WIDTH
) (
  input  logic                 Clk_CI,
  input  logic                 Reset_RI,
`ifdef SPATIAL_SEQ_STALL_EN
  input  logic                 Stall_SI,
`endif
  input  logic                 ValidIn_SI,
  output logic                 ReadyOut_SO,
  input  logic [NUM_CH*CW-1:0] FeaturesIn_DI,
  output logic                 Enable_SO,
  output logic                 FirstHypervector_SO,
  output logic [CW-1:0]        FeatureOut_DO,
  output logic [IDX_W-1:0]     ChannelIdx_DO,
  output logic                 StoreSecond_SO,
  output logic                 XorFinal_SO,
  output logic                 ValidOut_SO,
  input  logic                 ReadyIn_SI
);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  localparam logic [IDX_W-1:0] G_LAST  = IDX_W'(NUM_CH - 1);
  localparam logic [IDX_W-1:0] M0_LAST = IDX_W'(MOD0_CH - 1);
  localparam logic [IDX_W-1:0] M1_LAST = IDX_W'(MOD1_CH - 1);
  localparam logic [IDX_W-1:0] M2_LAST = IDX_W'(MOD2_CH - 1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  state_t                       state_q, state_d;
  logic [IDX_W-1:0]             g_q, g_d;
  logic [IDX_W-1:0]             m_q, m_d;
  logic [1:0]                   mod_q, mod_d;
  logic [NUM_CH-1:0][CW-1:0]    feat_q;
  logic                         feat_load;
  logic [IDX_W-1:0]             mod_last;
  logic                         stall;

`ifdef SPATIAL_SEQ_STALL_EN
  assign stall = Stall_SI;
`else
  assign stall = 1'b0;
`endif

  always_comb begin
    mod_last = M2_LAST;
    if (mod_q == 2'd0)      mod_last = M0_LAST;
    else if (mod_q == 2'd1) mod_last = M1_LAST;
  end

  always_ff @(posedge Clk_CI) begin
    if (Reset_RI) begin
      state_q <= IDLE;
      g_q     <= '0;
      m_q     <= '0;
      mod_q   <= '0;
      feat_q  <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      m_q     <= m_d;
      mod_q   <= mod_d;
      if (feat_load) feat_q <= FeaturesIn_DI;
    end
  end

  // Outputs depend only on registered state/counters (plus the stall gate on Enable).
  always_comb begin
    state_d             = state_q;
    g_d                 = g_q;
    m_d                 = m_q;
    mod_d               = mod_q;
    feat_load           = 1'b0;
    ReadyOut_SO         = 1'b0;
    Enable_SO           = 1'b0;
    FirstHypervector_SO = 1'b0;
    FeatureOut_DO       = '0;
    ChannelIdx_DO       = '0;
    StoreSecond_SO      = 1'b0;
    XorFinal_SO         = 1'b0;
    ValidOut_SO         = 1'b0;
    case (state_q)
      IDLE: begin
        ReadyOut_SO = 1'b1;
        if (ValidIn_SI) begin
          state_d   = SWEEP;
          g_d       = '0;
          m_d       = '0;
          mod_d     = '0;
          feat_load = 1'b1;
        end
      end
      SWEEP: begin
        ChannelIdx_DO       = g_q;
        FeatureOut_DO       = feat_q[g_q];
        FirstHypervector_SO = (g_q == '0);
        StoreSecond_SO      = (m_q == IDX_ONE);
        XorFinal_SO         = (m_q == mod_last);
        if (!stall) begin
          Enable_SO = 1'b1;
          if (g_q == G_LAST) begin
            state_d = DONE;
            g_d     = '0;
            m_d     = '0;
            mod_d   = '0;
          end else begin
            g_d = g_q + IDX_ONE;
            if (m_q == mod_last) begin
              m_d   = '0;
              mod_d = mod_q + 2'd1;
            end else begin
              m_d = m_q + IDX_ONE;
            end
          end
        end
      end
      DONE: begin
        ValidOut_SO = 1'b1;
        if (ReadyIn_SI) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spatial_sequencer.sv
// Directed bench for spatial_sequencer: default-parameter instance plus a 2/3/2-channel instance.
module tb_spatial_sequencer;
  localparam int W    = 2;
  localparam int NCH  = 217;
  localparam int IW   = 8;
  localparam int SNCH = 7;
  localparam int SIW  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic vin_a, rdy_a, rin_a, en_a, first_a, ss_a, xf_a, vo_a;
  logic [NCH*W-1:0] feat_a;
  logic [W-1:0]     fo_a;
  logic [IW-1:0]    idx_a;
  logic vin_b, rdy_b, rin_b, en_b, first_b, ss_b, xf_b, vo_b;
  logic [SNCH*W-1:0] feat_b;
  logic [W-1:0]      fo_b;
  logic [SIW-1:0]    idx_b;
`ifdef SPATIAL_SEQ_STALL_EN
  logic stall_a, stall_b;
`endif

  spatial_sequencer u_big (
    .Clk_CI(clk), .Reset_RI(rst),
`ifdef SPATIAL_SEQ_STALL_EN
    .Stall_SI(stall_a),
`endif
    .ValidIn_SI(vin_a), .ReadyOut_SO(rdy_a), .FeaturesIn_DI(feat_a),
    .Enable_SO(en_a), .FirstHypervector_SO(first_a), .FeatureOut_DO(fo_a),
    .ChannelIdx_DO(idx_a), .StoreSecond_SO(ss_a), .XorFinal_SO(xf_a),
    .ValidOut_SO(vo_a), .ReadyIn_SI(rin_a));

  spatial_sequencer #(.MOD0_CH(2), .MOD1_CH(3), .MOD2_CH(2)) u_small (
    .Clk_CI(clk), .Reset_RI(rst),
`ifdef SPATIAL_SEQ_STALL_EN
    .Stall_SI(stall_b),
`endif
    .ValidIn_SI(vin_b), .ReadyOut_SO(rdy_b), .FeaturesIn_DI(feat_b),
    .Enable_SO(en_b), .FirstHypervector_SO(first_b), .FeatureOut_DO(fo_b),
    .ChannelIdx_DO(idx_b), .StoreSecond_SO(ss_b), .XorFinal_SO(xf_b),
    .ValidOut_SO(vo_b), .ReadyIn_SI(rin_b));

  typedef struct {
    int sel;   // 0 = default instance, 1 = small instance
    int cyc;   // cycles after the accept edge (0 = channel 0)
    int en; int first; int ss; int xf; int vo; int rdy;
  } vec_t;

  vec_t tbl [20];
  int rb_flags [0:299];
  int rb_idx   [0:299];
  int rb_fo    [0:299];
  int rs_flags [0:15];
  int rs_fo    [0:15];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int flags(input logic en, first, ss, xf, vo, rdy);
    return int'({en, first, ss, xf, vo, rdy});
  endfunction

  task automatic accept_big(input int seed);
    @(negedge clk);
    for (int k = 0; k < NCH; k++) feat_a[k*W +: W] = W'((k + seed) % 4);
    vin_a = 1'b1;
    @(posedge clk);
    #1 vin_a = 1'b0;
  endtask

  task automatic cap_big(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      rb_flags[c] = flags(en_a, first_a, ss_a, xf_a, vo_a, rdy_a);
      rb_idx[c]   = int'(idx_a);
      rb_fo[c]    = int'(fo_a);
    end
  endtask

  // Called at the negedge of cycle c0; returns the cycle where ValidOut is seen, or -1.
  task automatic wait_vo_big(input int c0, output int c_hit);
    int c;
    c = c0;
    while (vo_a !== 1'b1 && c < 400) begin
      @(negedge clk);
      c++;
    end
    c_hit = (vo_a === 1'b1) ? c : -1;
  endtask

  initial begin
    int ss_cnt, xf_cnt, first_cnt, en_cnt, bad_idx, bad_fo, stable, hit;
    tbl[0]  = '{0, 0,   1, 1, 0, 0, 0, 0};
    tbl[1]  = '{0, 1,   1, 0, 1, 0, 0, 0};
    tbl[2]  = '{0, 31,  1, 0, 0, 1, 0, 0};
    tbl[3]  = '{0, 32,  1, 0, 0, 0, 0, 0};
    tbl[4]  = '{0, 33,  1, 0, 1, 0, 0, 0};
    tbl[5]  = '{0, 108, 1, 0, 0, 1, 0, 0};
    tbl[6]  = '{0, 109, 1, 0, 0, 0, 0, 0};
    tbl[7]  = '{0, 110, 1, 0, 1, 0, 0, 0};
    tbl[8]  = '{0, 216, 1, 0, 0, 1, 0, 0};
    tbl[9]  = '{0, 217, 0, 0, 0, 0, 1, 0};
    tbl[10] = '{0, 218, 0, 0, 0, 0, 0, 1};
    tbl[11] = '{1, 0,   1, 1, 0, 0, 0, 0};
    tbl[12] = '{1, 1,   1, 0, 1, 1, 0, 0};
    tbl[13] = '{1, 2,   1, 0, 0, 0, 0, 0};
    tbl[14] = '{1, 3,   1, 0, 1, 0, 0, 0};
    tbl[15] = '{1, 4,   1, 0, 0, 1, 0, 0};
    tbl[16] = '{1, 5,   1, 0, 0, 0, 0, 0};
    tbl[17] = '{1, 6,   1, 0, 1, 1, 0, 0};
    tbl[18] = '{1, 7,   0, 0, 0, 0, 1, 0};
    tbl[19] = '{1, 8,   0, 0, 0, 0, 0, 1};

    rst = 1'b1; vin_a = 1'b0; rin_a = 1'b1; feat_a = '0;
    vin_b = 1'b0; rin_b = 1'b1; feat_b = '0;
`ifdef SPATIAL_SEQ_STALL_EN
    stall_a = 1'b0; stall_b = 1'b0;
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_big_flags", flags(en_a, first_a, ss_a, xf_a, vo_a, rdy_a), 1);
    chk("reset_big_idx_fo", int'({idx_a, fo_a}), 0);
    chk("reset_small_flags", flags(en_b, first_b, ss_b, xf_b, vo_b, rdy_b), 1);

    // Full sweep, default parameters, ReadyIn high.
    accept_big(0);
    cap_big(220);

    // Small instance sweep.
    @(negedge clk);
    for (int k = 0; k < SNCH; k++) feat_b[k*W +: W] = W'((k + 1) % 4);
    vin_b = 1'b1;
    @(posedge clk);
    #1 vin_b = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      rs_flags[c] = flags(en_b, first_b, ss_b, xf_b, vo_b, rdy_b);
      rs_fo[c]    = int'(fo_b);
    end

    for (int i = 0; i < 20; i++) begin
      int act, exp;
      exp = flags(tbl[i].en[0], tbl[i].first[0], tbl[i].ss[0], tbl[i].xf[0], tbl[i].vo[0], tbl[i].rdy[0]);
      act = (tbl[i].sel == 0) ? rb_flags[tbl[i].cyc] : rs_flags[tbl[i].cyc];
      chk($sformatf("vec%0d_sel%0d_cyc%0d", i, tbl[i].sel, tbl[i].cyc), act, exp);
    end

    ss_cnt = 0; xf_cnt = 0; first_cnt = 0; en_cnt = 0; bad_idx = 0; bad_fo = 0;
    for (int c = 0; c < 220; c++) begin
      if (rb_flags[c][5]) en_cnt++;
      if (rb_flags[c][4]) first_cnt++;
      if (rb_flags[c][3]) ss_cnt++;
      if (rb_flags[c][2]) xf_cnt++;
      if (c < NCH && rb_idx[c] != c) bad_idx++;
      if (c < NCH && rb_fo[c] != c % 4) bad_fo++;
    end
    chk("enable_count", en_cnt, 217);
    chk("first_count", first_cnt, 1);
    chk("store_second_count", ss_cnt, 3);
    chk("xor_final_count", xf_cnt, 3);
    chk("channel_idx_errs", bad_idx, 0);
    chk("feature_errs", bad_fo, 0);
    bad_fo = 0;
    for (int c = 0; c < SNCH; c++) if (rs_fo[c] != (c + 1) % 4) bad_fo++;
    chk("small_feature_errs", bad_fo, 0);

    // DONE held with ReadyIn low; ValidIn pulses must be ignored.
    rin_a = 1'b0;
    accept_big(1);
    @(negedge clk);
    wait_vo_big(0, hit);
    chk("hold_vo_cycle", hit, 217);
    stable = 0;
    for (int i = 0; i < 10; i++) begin
      if (vo_a === 1'b1 && en_a === 1'b0 && rdy_a === 1'b0) stable++;
      vin_a = i[0];
      @(negedge clk);
    end
    chk("hold_stable_cycles", stable, 10);
    vin_a = 1'b0;
    rin_a = 1'b1;
    @(negedge clk);
    chk("release_idle_flags", flags(en_a, first_a, ss_a, xf_a, vo_a, rdy_a), 1);
    @(negedge clk);
    chk("no_phantom_sweep", flags(en_a, first_a, ss_a, xf_a, vo_a, rdy_a), 1);

    // Reset in the middle of a sweep, then a fresh sample.
    accept_big(2);
    for (int c = 0; c <= 100; c++) @(negedge clk);
    chk("pre_reset_idx", int'(idx_a), 100);
    rst = 1'b1;
    @(negedge clk);
    chk("midreset_flags", flags(en_a, first_a, ss_a, xf_a, vo_a, rdy_a), 1);
    chk("midreset_idx_fo", int'({idx_a, fo_a}), 0);
    rst = 1'b0;
    vin_a = 1'b1;
    @(posedge clk);
    #1 vin_a = 1'b0;
    @(negedge clk);
    chk("restart_flags", flags(en_a, first_a, ss_a, xf_a, vo_a, rdy_a), 6'b110000);
    chk("restart_idx", int'(idx_a), 0);
    wait_vo_big(0, hit);
    chk("restart_vo_cycle", hit, 217);
    @(negedge clk);

`ifdef SPATIAL_SEQ_STALL_EN
    // Five stalled cycles at channel 50 delay ValidOut by five cycles.
    accept_big(3);
    for (int c = 0; c <= 50; c++) @(negedge clk);
    chk("stall_pre_idx", int'(idx_a), 50);
    stall_a = 1'b1;
    stable = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (idx_a == IW'(50) && en_a === 1'b0) stable++;
      @(negedge clk);
    end
    stall_a = 1'b0;
    chk("stall_hold_cycles", stable, 5);
    #1 chk("stall_resume", int'({en_a, idx_a}), (1 << IW) | 50);
    wait_vo_big(55, hit);
    chk("stall_vo_cycle", hit, 222);
    @(negedge clk);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
